// File: rtl/alu_result_mux.sv
// alu_result_mux: waits for a selected ALU channel to report done, then
// captures its result and holds it until the consumer takes it. A bad
// channel index or a wait longer than TIMEOUT yields an error result.

// Per-channel match: passes done/data through only when this channel is selected.
module alu_result_lane #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 3,
  parameter int IDX   = 0
) (
  input  logic [SEL_W-1:0] sel,
  input  logic             done,
  input  logic [WIDTH-1:0] data,
  output logic             hit_done,
  output logic [WIDTH-1:0] hit_data
);
  localparam logic [SEL_W-1:0] ID = SEL_W'(IDX);

  logic hit;
  assign hit      = (sel == ID);
  assign hit_done = hit & done;
  assign hit_data = hit ? data : '0;
endmodule

module alu_result_mux #(
  parameter int WIDTH   = 8,
  parameter int N_IN    = 8,
  parameter int SEL_W   = 3,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [SEL_W-1:0]      op_sel,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [N_IN-1:0]       in_done,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [WIDTH-1:0]      res_data,
  output logic [SEL_W-1:0]      res_sel,
  output logic                  res_err
);
  // 16 bits covers the full TIMEOUT range
  localparam int              CNT_W = 16;
  localparam logic [CNT_W-1:0] TMO   = CNT_W'(TIMEOUT);
  localparam logic [SEL_W:0]   N_LIM = (SEL_W+1)'(N_IN);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [WIDTH-1:0] data_nxt;
  logic [SEL_W-1:0] sel_nxt;
  logic             err_nxt;

  logic [N_IN-1:0]            lane_done;
  logic [N_IN-1:0][WIDTH-1:0] lane_data;
  logic                       sel_done;
  logic [WIDTH-1:0]           sel_data;
  logic                       bad_sel;

  // Lanes are steered by the latched index, so only the selected channel
  // can ever contribute; every other lane drives zero.
  for (genvar i = 0; i < N_IN; i++) begin : g_lane
    alu_result_lane #(.WIDTH(WIDTH), .SEL_W(SEL_W), .IDX(i)) u_lane (
      .sel      (res_sel),
      .done     (in_done[i]),
      .data     (in_data[i*WIDTH +: WIDTH]),
      .hit_done (lane_done[i]),
      .hit_data (lane_data[i])
    );
  end

  // OR-combine the one-hot lane outputs into the selected channel's result
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_IN; i++) sel_data |= lane_data[i];
  end

  assign sel_done  = |lane_done;
  assign bad_sel   = ({1'b0, op_sel} >= N_LIM);
  // Saturating increment: the counter leaves WAIT at TMO, but never wraps anyway
  assign cnt_inc   = (cnt == TMO) ? cnt : cnt + 1'b1;
  assign op_ready  = (state == IDLE);
  assign res_valid = (state == HOLD);

  // Next-state and next-result decode
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    data_nxt  = res_data;
    sel_nxt   = res_sel;
    err_nxt   = res_err;
    case (state)
      IDLE: if (op_valid) begin
        sel_nxt = op_sel;
        cnt_nxt = '0;
        if (bad_sel) begin
          data_nxt  = '0;
          err_nxt   = 1'b1;
          state_nxt = HOLD;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // done wins over a timeout landing in the same cycle
        if (sel_done) begin
          data_nxt  = sel_data;
          err_nxt   = 1'b0;
          state_nxt = HOLD;
        end else begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == TMO) begin
            data_nxt  = '0;
            err_nxt   = 1'b1;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State and result registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      res_data <= '0;
      res_sel  <= '0;
      res_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      res_data <= data_nxt;
      res_sel  <= sel_nxt;
      res_err  <= err_nxt;
    end
  end
endmodule

// File: tb/tb_alu_result_mux.sv
// Bench for alu_result_mux: two instances (8-bit/7 channels/TIMEOUT 12 and
// 16-bit/16 channels/TIMEOUT 4), scoreboard queues of expected results
// compared whenever res_valid is high, plus directed timing checks.
module tb_alu_result_mux;
  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  sel;
    logic        err;
  } exp_t;

  logic clk, rst_n;
  int   n_chk = 0, n_err = 0;
  exp_t a_q[$], b_q[$];

  // instance A
  logic        a_op_valid, a_op_ready, a_res_valid, a_res_ready, a_res_err;
  logic [2:0]  a_op_sel, a_res_sel;
  logic [55:0] a_in_data;
  logic [6:0]  a_in_done;
  logic [7:0]  a_res_data;

  // instance B
  logic         b_op_valid, b_op_ready, b_res_valid, b_res_ready, b_res_err;
  logic [3:0]   b_op_sel, b_res_sel;
  logic [255:0] b_in_data;
  logic [15:0]  b_in_done;
  logic [15:0]  b_res_data;

  alu_result_mux #(.WIDTH(8), .N_IN(7), .SEL_W(3), .TIMEOUT(12)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .op_valid(a_op_valid), .op_ready(a_op_ready),
    .op_sel(a_op_sel), .in_data(a_in_data), .in_done(a_in_done),
    .res_valid(a_res_valid), .res_ready(a_res_ready), .res_data(a_res_data),
    .res_sel(a_res_sel), .res_err(a_res_err)
  );

  alu_result_mux #(.WIDTH(16), .N_IN(16), .SEL_W(4), .TIMEOUT(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .op_valid(b_op_valid), .op_ready(b_op_ready),
    .op_sel(b_op_sel), .in_data(b_in_data), .in_done(b_in_done),
    .res_valid(b_res_valid), .res_ready(b_res_ready), .res_data(b_res_data),
    .res_sel(b_res_sel), .res_err(b_res_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // scoreboard A: every offered result must match the oldest expectation
  always @(negedge clk) begin
    if (a_res_valid === 1'b1) begin
      if (a_q.size() == 0) chk("a_unexpected_result", 1, 0);
      else begin
        chk("a_sb_data", {24'd0, a_res_data}, {16'd0, a_q[0].data});
        chk("a_sb_sel",  {29'd0, a_res_sel},  {28'd0, a_q[0].sel});
        chk("a_sb_err",  {31'd0, a_res_err},  {31'd0, a_q[0].err});
        if (a_res_ready) void'(a_q.pop_front());
      end
    end
  end

  // scoreboard B
  always @(negedge clk) begin
    if (b_res_valid === 1'b1) begin
      if (b_q.size() == 0) chk("b_unexpected_result", 1, 0);
      else begin
        chk("b_sb_data", {16'd0, b_res_data}, {16'd0, b_q[0].data});
        chk("b_sb_sel",  {28'd0, b_res_sel},  {28'd0, b_q[0].sel});
        chk("b_sb_err",  {31'd0, b_res_err},  {31'd0, b_q[0].err});
        if (b_res_ready) void'(b_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    a_op_valid = 0; a_op_sel = 0; a_in_data = '0; a_in_done = '0; a_res_ready = 0;
    b_op_valid = 0; b_op_sel = 0; b_in_data = '0; b_in_done = '0; b_res_ready = 0;
    cyc(); cyc();
    chk("rst_op_ready", a_op_ready, 1);
    chk("rst_res_valid", a_res_valid, 0);
    chk("rst_res_data", a_res_data, 0);
    chk("rst_res_sel", a_res_sel, 0);
    chk("rst_res_err", a_res_err, 0);
    chk("rst_b_op_ready", b_op_ready, 1);
    chk("rst_b_res_data", b_res_data, 0);
    rst_n = 1;

    // basic: op_sel=4, done one cycle after accept, noise on other channels
    for (int i = 0; i < 7; i++) a_in_data[i*8 +: 8] = 8'($urandom);
    a_in_data[4*8 +: 8] = 8'h3C;
    a_op_valid = 1; a_op_sel = 4;
    a_q.push_back('{16'h003C, 4'd4, 1'b0});
    cyc();
    a_op_valid = 0;
    chk("lat_ready_wait", a_op_ready, 0);
    chk("lat_valid_wait", a_res_valid, 0);
    a_in_done = 7'b0011000;
    cyc();
    chk("lat_valid_2cyc", a_res_valid, 1);
    a_in_done = '0;
    a_res_ready = 1;
    cyc();
    a_res_ready = 0;
    chk("hs_valid_low", a_res_valid, 0);
    chk("hs_ready_back", a_op_ready, 1);
    chk("idle_data_kept", a_res_data, 8'h3C);

    // long wait with ignored traffic, then held result under backpressure
    a_op_valid = 1; a_op_sel = 0;
    a_q.push_back('{16'h0007, 4'd0, 1'b0});
    cyc();
    for (int i = 0; i < 9; i++) begin
      chk("w32_ready", a_op_ready, 0);
      chk("w32_valid", a_res_valid, 0);
      a_op_valid = 1; a_op_sel = 3;      // ignored outside IDLE
      a_in_done = 7'b0000010;            // unselected channel
      a_in_data[0 +: 8] = 8'($urandom);
      cyc();
    end
    a_op_valid = 0;
    a_in_data[0 +: 8] = 8'h07;
    a_in_done = 7'b0000001;
    cyc();
    a_in_done = 7'b0000001;              // selected channel in HOLD: ignored
    a_in_data[0 +: 8] = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      chk("h32_valid", a_res_valid, 1);
      chk("h32_ready", a_op_ready, 0);
      chk("h32_data", a_res_data, 8'h07);
      cyc();
    end
    a_in_done = '0;
    a_res_ready = 1;
    cyc();
    a_res_ready = 0;
    chk("h32_done_valid", a_res_valid, 0);
    chk("h32_done_ready", a_op_ready, 1);

    // out-of-range index (N_IN=7, op_sel=7)
    a_op_valid = 1; a_op_sel = 7;
    a_q.push_back('{16'h0000, 4'd7, 1'b1});
    cyc();
    a_op_valid = 0;
    chk("bad_valid", a_res_valid, 1);
    chk("bad_err", a_res_err, 1);
    chk("bad_data", a_res_data, 0);
    a_res_ready = 1;
    cyc();
    a_res_ready = 0;

    // done arriving in the last WAIT cycle before timeout wins; res_ready in WAIT ignored
    a_op_valid = 1; a_op_sel = 5;
    a_q.push_back('{16'h00A5, 4'd5, 1'b0});
    cyc();
    a_op_valid = 0;
    a_res_ready = 1;
    for (int i = 0; i < 11; i++) begin
      chk("edge_valid", a_res_valid, 0);
      cyc();
    end
    a_in_data[5*8 +: 8] = 8'hA5;
    a_in_done = 7'b0100000;
    cyc();
    a_in_done = '0;
    chk("edge_hold", a_res_valid, 1);
    chk("edge_err", a_res_err, 0);
    cyc();
    a_res_ready = 0;
    chk("edge_done", a_res_valid, 0);

    // stuck in WAIT (wrong channel done), then reset clears everything
    a_op_valid = 1; a_op_sel = 2;
    cyc();
    a_op_valid = 0;
    a_in_done = 7'b0001000;
    for (int i = 0; i < 3; i++) begin
      chk("stuck_valid", a_res_valid, 0);
      chk("stuck_ready", a_op_ready, 0);
      cyc();
    end
    a_in_done = '0;
    rst_n = 0;
    cyc();
    rst_n = 1;
    chk("mid_rst_ready", a_op_ready, 1);
    chk("mid_rst_valid", a_res_valid, 0);
    chk("mid_rst_data", a_res_data, 0);
    chk("mid_rst_sel", a_res_sel, 0);
    chk("mid_rst_err", a_res_err, 0);

    // reset during HOLD discards the pending result
    a_op_valid = 1; a_op_sel = 7;
    a_q.push_back('{16'h0000, 4'd7, 1'b1});
    cyc();
    a_op_valid = 0;
    chk("hold_rst_pre", a_res_valid, 1);
    rst_n = 0;
    cyc();
    rst_n = 1;
    a_q.delete();
    chk("hold_rst_valid", a_res_valid, 0);
    chk("hold_rst_err", a_res_err, 0);

    // request coincident with reset is dropped
    a_op_valid = 1; a_op_sel = 1;
    rst_n = 0;
    cyc();
    a_op_valid = 0;
    rst_n = 1;
    chk("rst_drop_ready", a_op_ready, 1);
    cyc();
    chk("rst_drop_valid", a_res_valid, 0);
    chk("rst_drop_ready2", a_op_ready, 1);

    // B: timeout after 4 WAIT cycles, done pulses in HOLD ignored
    b_op_valid = 1; b_op_sel = 6;
    b_q.push_back('{16'h0000, 4'd6, 1'b1});
    cyc();
    b_op_valid = 0;
    for (int i = 0; i < 4; i++) begin
      chk("tmo_wait", b_res_valid, 0);
      cyc();
    end
    chk("tmo_hold", b_res_valid, 1);
    chk("tmo_err", b_res_err, 1);
    b_in_data[6*16 +: 16] = 16'h1234;
    b_in_done = 16'h0040;
    cyc(); cyc();
    b_in_done = '0;
    chk("tmo_data", b_res_data, 0);
    b_res_ready = 1;
    cyc();
    b_res_ready = 0;
    chk("tmo_idle", b_op_ready, 1);

    // B: top channel with distinct neighbours, then channel 0
    for (int i = 0; i < 16; i++) b_in_data[i*16 +: 16] = 16'($urandom);
    b_in_data[15*16 +: 16] = 16'hBEEF;
    b_in_data[14*16 +: 16] = 16'h1111;
    b_in_data[0 +: 16]     = 16'hCAFE;
    b_op_valid = 1; b_op_sel = 15;
    b_q.push_back('{16'hBEEF, 4'd15, 1'b0});
    cyc();
    b_op_valid = 0;
    b_in_done = 16'hC000;
    b_res_ready = 1;
    cyc();
    b_in_done = '0;
    chk("wide_data", b_res_data, 16'hBEEF);
    cyc();
    b_op_valid = 1; b_op_sel = 0;
    b_q.push_back('{16'hCAFE, 4'd0, 1'b0});
    cyc();
    b_op_valid = 0;
    b_in_done = 16'h0001;
    cyc();
    b_in_done = '0;
    chk("wide_ch0", b_res_data, 16'hCAFE);
    cyc();
    b_res_ready = 0;

    cyc(); cyc();
    chk("a_q_empty", a_q.size(), 0);
    chk("b_q_empty", b_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/alu_result_mux.md
ALU_RESULT_MUX -- requirements
Module: alu_result_mux

Interface
- REQ-001: WIDTH, 8, bit width of each operand channel and of the result.
- REQ-002: N_IN, 8, number of input channels (2..16).
- REQ-003: SEL_W, 3, selector width; SHALL satisfy 2**SEL_W >= N_IN.
- REQ-004: TIMEOUT, 255, maximum WAIT cycles before abort (1..65535).
- REQ-005: clk  input  1  single clock; all state updates on rising edge.
- REQ-006: rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- REQ-007: op_valid  input  1  request to select a channel.
- REQ-008: op_ready  output  1  block can accept a request.
- REQ-009: op_sel  input  SEL_W  channel index; 0=DIV, 1=AND, 2=OR, 3=XOR, 4=ADD, 5=SUB, 6=MULT, 7=spare at default N_IN.
- REQ-010: in_data  input  N_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- REQ-011: in_done  input  N_IN  channel i result is valid this cycle.
- REQ-012: res_valid  output  1  result held and offered.
- REQ-013: res_ready  input  1  consumer accepts the result.
- REQ-014: res_data  output  WIDTH  captured result.
- REQ-015: res_sel  output  SEL_W  channel index that produced res_data.
- REQ-016: res_err  output  1  result invalid (bad index or timeout); qualified by res_valid.

Function
- REQ-017: FSM states SHALL be IDLE, WAIT, HOLD; op_ready SHALL be 1 only in IDLE.
- REQ-018: IDLE + op_valid SHALL accept the request at that edge, latch op_sel into res_sel, clear the wait counter, and go to WAIT.
- REQ-019: IDLE + op_valid with op_sel >= N_IN SHALL instead go directly to HOLD with res_data=0 and res_err=1.
- REQ-020: WAIT SHALL sample in_done[res_sel] each cycle; when it is 1, the block SHALL capture in_data slice res_sel into res_data, set res_err=0, and go to HOLD at that edge.
- REQ-021: latency: in_done high in WAIT cycle k SHALL give res_valid=1 in cycle k+1; minimum request-to-result latency is 2 cycles.
- REQ-022: in_done and in_data of unselected channels, and of the selected channel outside WAIT, SHALL be ignored.
- REQ-023: WAIT counter SHALL increment each WAIT cycle without done; when it reaches TIMEOUT, the block SHALL go to HOLD with res_data=0 and res_err=1; the counter SHALL never wrap.
- REQ-024: HOLD SHALL drive res_valid=1; res_data, res_sel and res_err SHALL stay stable until res_ready=1.
- REQ-025: HOLD + res_ready SHALL complete the transfer and return to IDLE at that edge; res_valid SHALL go to 0 in the next cycle.
- REQ-026: res_ready outside HOLD SHALL have no effect, and op_valid outside IDLE SHALL be ignored; a request is not queued.
- REQ-027: res_data SHALL retain its last captured value in IDLE and WAIT; res_valid=0 there.

Reset
- REQ-028: rst_n=0 at a rising edge SHALL force IDLE in every state, including mid-WAIT and mid-HOLD, and SHALL discard any pending result.
- REQ-029: reset values SHALL be: op_ready=1 (IDLE), res_valid=0, res_data=0, res_sel=0, res_err=0, wait counter=0.
- REQ-030: a request presented in the same cycle as rst_n=0 SHALL be dropped.

Verification
- REQ-031: op_sel=4, in_done[4]=1 with data 8'h3C one cycle after accept -> res_valid after 2 cycles, res_data=8'h3C, res_sel=4, res_err=0.
- REQ-032: op_sel=0, in_done[0] asserted 10 cycles later with 8'h07, res_ready held 0 for 5 cycles -> res_data stays 8'h07 throughout, with op_ready=0 until the handshake completes.
- REQ-033: N_IN=7, op_sel=7 -> res_valid the next cycle with res_data=0 and res_err=1.
- REQ-034: TIMEOUT=4, op_sel=6, in_done never asserted -> HOLD after 4 WAIT cycles with res_err=1; in_done[6] pulsing in HOLD leaves res_data unchanged.
- REQ-035: op_sel=2 with in_done[3]=1 only -> stays in WAIT; then rst_n=0 for 1 cycle -> IDLE, all outputs at reset values, op_ready=1.
- REQ-036: WIDTH=16, N_IN=16, op_sel=15, data 16'hBEEF -> res_data=16'hBEEF, with no aliasing from adjacent slices.
